calc_seq_core: RTL and testbench

Parametrised, clocked successor to the 4-bit board calculator. It performs signed two's-complement add, subtract, absolute value and multi-cycle multiply on W-bit operands, with operand swap, an accumulator, a start/busy/done handshake and a sticky overflow flag. It sits between the switch/key input registers and the hex display decoders. Display formatting, including showing E on overflow, stays in the decoders.

---
 rtl/calc_seq_core.sv | 156 +++++++++++++++
 tb/tb_calc_seq_core.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/calc_seq_core.sv
// Signed W-bit calculator core: single-cycle add/sub/abs, iterative shift-add multiply,
// accumulator feedback, start/busy/done handshake and sticky overflow.
module calc_seq_core #(
    parameter int W = 4
) (
    input  logic         CLOCK_50,
    input  logic         reset_n,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         acc_sel,
    input  logic         clr_sticky,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         ovf,
    output logic         ovf_sticky
);
    localparam int CW = (W > 2) ? $clog2(W) : 1;

    // state  | meaning
    // S_IDLE | waiting for start; single-cycle ops complete here
    // S_MUL  | one shift-add partial product per cycle
    // S_FIN  | apply product sign, load result/ovf/acc
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_FIN = 2'd2} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   mx_q, mx_d, my_q, my_d;
    logic [2*W-1:0] prod_q, prod_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           neg_q, neg_d;
    logic [W-1:0]   acc_q, acc_d, result_q, result_d;
    logic           ovf_q, ovf_d, sticky_q, sticky_d, done_q, done_d;

    logic [W-1:0]   a_sel, x_op, y_op, sum, diff, absy, res_1c;
    logic           ovf_1c;
    logic [2*W-1:0] prod_s;
    logic [W:0]     prod_hi;

    function automatic logic [W-1:0] mag(input logic [W-1:0] v);
        return v[W-1] ? (~v + W'(1)) : v;
    endfunction

    always_comb begin
        state_d  = state_q;
        mx_d     = mx_q;
        my_d     = my_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        acc_d    = acc_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;

        a_sel = acc_sel ? acc_q : a;
        x_op  = op[2] ? b : a_sel;
        y_op  = op[2] ? a_sel : b;
        sum   = x_op + y_op;
        diff  = x_op - y_op;
        absy  = mag(y_op);

        case (op[1:0])
            2'b00: begin
                res_1c = sum;
                ovf_1c = (x_op[W-1] == y_op[W-1]) && (sum[W-1] != x_op[W-1]);
            end
            2'b01: begin
                res_1c = diff;
                ovf_1c = (x_op[W-1] != y_op[W-1]) && (diff[W-1] != x_op[W-1]);
            end
            default: begin
                res_1c = absy;
                // only the most negative value keeps its sign bit after negation
                ovf_1c = y_op[W-1] & absy[W-1];
            end
        endcase

        prod_s  = neg_q ? (~prod_q + (2*W)'(1)) : prod_q;
        prod_hi = prod_s[2*W-1:W-1];

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (op[1:0] == 2'b11) begin
                        state_d = S_MUL;
                        mx_d    = mag(x_op);
                        my_d    = mag(y_op);
                        neg_d   = x_op[W-1] ^ y_op[W-1];
                        prod_d  = '0;
                        cnt_d   = '0;
                    end else begin
                        result_d = res_1c;
                        ovf_d    = ovf_1c;
                        acc_d    = res_1c;
                        done_d   = 1'b1;
                    end
                end
            end
            S_MUL: begin
                if (my_q[cnt_q]) begin
                    prod_d = prod_q + ({{W{1'b0}}, mx_q} << cnt_q);
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                result_d = prod_s[W-1:0];
                ovf_d    = ~((&prod_hi) | ~(|prod_hi));
                acc_d    = prod_s[W-1:0];
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        sticky_d = (sticky_q & ~clr_sticky) | (done_d & ovf_d);
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            mx_q     <= '0;
            my_q     <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            sticky_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mx_q     <= mx_d;
            my_q     <= my_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            sticky_q <= sticky_d;
            done_q   <= done_d;
        end
    end

    assign busy       = (state_q == S_MUL);
    assign done       = done_q;
    assign result     = result_q;
    assign ovf        = ovf_q;
    assign ovf_sticky = sticky_q;
endmodule

// File: tb/tb_calc_seq_core.sv
// Bench for calc_seq_core: integer-arithmetic reference model compared every cycle,
// directed literal cases, then randomized traffic with occasional resets.
module tb_calc_seq_core;
    localparam int W  = 4;
    localparam int LO = -(1 << (W - 1));
    localparam int HI = (1 << (W - 1)) - 1;

    logic         CLOCK_50 = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op = 3'b000;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         acc_sel = 1'b0;
    logic         clr_sticky = 1'b0;
    logic         busy, done, ovf, ovf_sticky;
    logic [W-1:0] result;

    int n_pass = 0;
    int n_total = 0;

    calc_seq_core #(.W(W)) dut (
        .CLOCK_50  (CLOCK_50),
        .reset_n   (reset_n),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .acc_sel   (acc_sel),
        .clr_sticky(clr_sticky),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .ovf       (ovf),
        .ovf_sticky(ovf_sticky)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Reference: exact integer result; overflow means it leaves the W-bit signed range.
    function automatic int exact(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
        int x, y;
        x = o[2] ? int'($signed(bv)) : int'($signed(av));
        y = o[2] ? int'($signed(av)) : int'($signed(bv));
        case (o[1:0])
            2'b00:   return x + y;
            2'b01:   return x - y;
            2'b10:   return (y < 0) ? -y : y;
            default: return x * y;
        endcase
    endfunction

    int           m_rem = 0;  // edges until a multiply completes; 0 = idle
    logic [W-1:0] m_res = '0, m_pres = '0, m_acc = '0;
    logic         m_ovf = 1'b0, m_povf = 1'b0, m_sticky = 1'b0, m_done = 1'b0;
    int           t_p;
    logic [W-1:0] t_res;
    logic         t_ovf;

    always_comb begin
        t_p   = exact(op, acc_sel ? m_acc : a, b);
        t_res = W'(t_p);
        t_ovf = (t_p < LO) || (t_p > HI);
    end

    always @(posedge CLOCK_50) begin
        if (!reset_n) begin
            m_rem <= 0; m_res <= '0; m_acc <= '0; m_ovf <= 1'b0;
            m_sticky <= 1'b0; m_done <= 1'b0;
        end else if (m_rem == 1) begin
            m_rem <= 0; m_res <= m_pres; m_ovf <= m_povf; m_acc <= m_pres; m_done <= 1'b1;
            m_sticky <= (m_sticky && !clr_sticky) || m_povf;
        end else if (m_rem > 1) begin
            m_rem <= m_rem - 1; m_done <= 1'b0;
            m_sticky <= m_sticky && !clr_sticky;
        end else if (start && op[1:0] == 2'b11) begin
            m_rem <= W + 1; m_pres <= t_res; m_povf <= t_ovf; m_done <= 1'b0;
            m_sticky <= m_sticky && !clr_sticky;
        end else if (start) begin
            m_res <= t_res; m_ovf <= t_ovf; m_acc <= t_res; m_done <= 1'b1;
            m_sticky <= (m_sticky && !clr_sticky) || t_ovf;
        end else begin
            m_done <= 1'b0;
            m_sticky <= m_sticky && !clr_sticky;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic tick(input logic st, input logic [2:0] o, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input logic as, input logic cl, input logic rn);
        start = st; op = o; a = av; b = bv; acc_sel = as; clr_sticky = cl; reset_n = rn;
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        chk("cmp_done",   int'(done),       int'(m_done));
        chk("cmp_busy",   int'(busy),       int'(m_rem > 1));
        chk("cmp_result", int'(result),     int'(m_res));
        chk("cmp_ovf",    int'(ovf),        int'(m_ovf));
        chk("cmp_sticky", int'(ovf_sticky), int'(m_sticky));
    endtask

    task automatic run_op(input string nm, input logic [2:0] o, input logic [W-1:0] av,
                          input logic [W-1:0] bv, input logic [W-1:0] er, input logic eo,
                          input int elat, input int ebusy, input logic poke);
        int lat, bc;
        lat = 0;
        bc  = 0;
        tick(1'b1, o, av, bv, 1'b0, 1'b0, 1'b1);
        bc += int'(busy);
        while (!done && lat < W + 3) begin
            tick(poke && lat == 1, 3'b000, av, bv, 1'b0, 1'b0, 1'b1);
            lat++;
            bc += int'(busy);
        end
        chk({nm, "_done"},   int'(done),   1);
        chk({nm, "_lat"},    lat,          elat);
        chk({nm, "_busy"},   bc,           ebusy);
        chk({nm, "_result"}, int'(result), int'(er));
        chk({nm, "_ovf"},    int'(ovf),    int'(eo));
    endtask

    initial begin
        tick(1'b0, 3'b000, '0, '0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 3'b000, '0, '0, 1'b0, 1'b0, 1'b0);
        chk("rst_result", int'(result), 0);
        chk("rst_busy",   int'(busy),   0);
        chk("rst_done",   int'(done),   0);
        chk("rst_sticky", int'(ovf_sticky), 0);

        for (int i = 1; i <= 3; i++) begin
            tick(1'b1, 3'b000, 4'd9, 4'd1, 1'b1, 1'b0, 1'b1);
            chk("acc_done",   int'(done),   1);
            chk("acc_result", int'(result), i);
        end

        run_op("add_4_3", 3'b000, 4'd4, 4'd3, 4'd7, 1'b0, 0, 0, 1'b0);
        run_op("add_7_1", 3'b000, 4'd7, 4'd1, 4'b1000, 1'b1, 0, 0, 1'b0);
        chk("sticky_set", int'(ovf_sticky), 1);
        tick(1'b0, 3'b000, '0, '0, 1'b0, 1'b1, 1'b1);
        chk("sticky_clr", int'(ovf_sticky), 0);
        run_op("add_m8_m8", 3'b000, 4'b1000, 4'b1000, 4'b0000, 1'b1, 0, 0, 1'b0);

        run_op("sub_5_2",   3'b001, 4'd5, 4'd2, 4'd3, 1'b0, 0, 0, 1'b0);
        run_op("subsw_2_5", 3'b101, 4'd2, 4'd5, 4'd3, 1'b0, 0, 0, 1'b0);
        run_op("sub_5_m4",  3'b001, 4'd5, 4'b1100, 4'b1001, 1'b1, 0, 0, 1'b0);
        run_op("subsw_m7",  3'b101, 4'b1001, 4'b1001, 4'd0, 1'b0, 0, 0, 1'b0);

        run_op("abs_m8",    3'b010, 4'd0, 4'b1000, 4'b1000, 1'b1, 0, 0, 1'b0);
        run_op("abs_7",     3'b010, 4'd0, 4'd7, 4'd7, 1'b0, 0, 0, 1'b0);
        run_op("abssw_m4",  3'b110, 4'b1100, 4'd5, 4'd4, 1'b0, 0, 0, 1'b0);
        run_op("abssw_0",   3'b110, 4'd0, 4'd5, 4'd0, 1'b0, 0, 0, 1'b0);

        run_op("mul_3_m2",  3'b011, 4'd3, 4'b1110, 4'b1010, 1'b0, W + 1, W, 1'b1);
        run_op("mul_4_4",   3'b011, 4'd4, 4'd4, 4'd0, 1'b1, W + 1, W, 1'b0);
        run_op("mul_m8_1",  3'b011, 4'b1000, 4'd1, 4'b1000, 1'b0, W + 1, W, 1'b0);

        tick(1'b1, 3'b011, 4'd3, 4'd2, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 3'b000, 4'd3, 4'd2, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 3'b000, 4'd3, 4'd2, 1'b0, 1'b0, 1'b0);
        chk("abort_busy",   int'(busy),   0);
        chk("abort_done",   int'(done),   0);
        chk("abort_result", int'(result), 0);
        chk("abort_ovf",    int'(ovf),    0);
        for (int i = 0; i < W + 2; i++) begin
            tick(1'b0, 3'b000, 4'd3, 4'd2, 1'b0, 1'b0, 1'b1);
            chk("abort_nodone", int'(done), 0);
        end
        run_op("post_add",  3'b000, 4'd2, 4'd2, 4'd4, 1'b0, 0, 0, 1'b0);

        for (int i = 0; i < 600; i++) begin
            tick($urandom_range(0, 2) != 0, 3'($urandom), W'($urandom), W'($urandom),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 63) != 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
